ahb_bus_arbiter: RTL

//  Central AHB arbiter. Shares one AHB bus between MASTER_NUM masters.
//  - Takes per-master hbusreq/hlock and the bus-wide hready/htrans/hburst.
//  - Drives one-hot hgrant, the address-phase owner hmaster, and hmastlock.
//  - Sits between the master agents' request interfaces and the shared

---
 rtl/ahb_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// Central AHB bus arbiter: one-hot registered grant, registered address-phase owner,
// burst-aware re-arbitration and locked transfers. Define AHB_ARB_ROUND_ROBIN_EN for rotating priority.
module ahb_bus_arbiter #(
    parameter int MASTER_NUM = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [MASTER_NUM-1:0] hbusreq,
    input  logic [MASTER_NUM-1:0] hlock,
    input  logic                  hready,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    output logic [MASTER_NUM-1:0] hgrant,
    output logic [3:0]            hmaster,
    output logic                  hmastlock
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [MASTER_NUM-1:0] DEFAULT_GNT = {1'b1, {(MASTER_NUM-1){1'b0}}};
    localparam logic [3:0]            DEFAULT_IDX = 4'(MASTER_NUM - 1);

    logic [MASTER_NUM-1:0] hgrant_q;
    logic [MASTER_NUM-1:0] hgrant_d;
    logic [3:0]            hmaster_q;
    logic [3:0]            cnt_q;
    logic [3:0]            cnt_d;
    logic                  arb_ok_s;
    logic                  lock_hold_s;
    logic [MASTER_NUM-1:0] pick_s;

    // Remaining beats after the NONSEQ of a fixed-length burst; undefined-length bursts stay at 0.
    function automatic logic [3:0] burst_beats(input logic [2:0] burst);
        logic [3:0] beats;
        case (burst)
            3'b010, 3'b011: beats = 4'd3;
            3'b100, 3'b101: beats = 4'd7;
            3'b110, 3'b111: beats = 4'd15;
            default:        beats = 4'd0;
        endcase
        return beats;
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [MASTER_NUM-1:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            idx = idx | (oh[i] ? 4'(i) : 4'd0);
        end
        return idx;
    endfunction

    // Lowest set bit wins, so index 0 is the highest priority.
    function automatic logic [MASTER_NUM-1:0] lowest_set(input logic [MASTER_NUM-1:0] v);
        logic [MASTER_NUM-1:0] r;
        r = {MASTER_NUM{1'b0}};
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = {MASTER_NUM{1'b0}};
                r[i] = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Beat counter next state; a new grant is only allowed once no burst beats remain.
    always_comb begin
        cnt_d = cnt_q;
        if (hready) begin
            case (htrans)
                TRANS_NONSEQ: cnt_d = burst_beats(hburst);
                TRANS_SEQ:    cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
                TRANS_IDLE:   cnt_d = 4'd0;
                default:      cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign arb_ok_s    = (cnt_d == 4'd0);
    assign lock_hold_s = |(hlock & hbusreq & hgrant_q);
    assign hmastlock   = |(hlock & hgrant_q);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [3:0]              rr_q;
    logic [3:0]              rr_d;
    logic [2*MASTER_NUM-1:0] req_dbl_s;
    logic [MASTER_NUM-1:0]   pick_rot_s;
    logic [2*MASTER_NUM-1:0] pick_dbl_s;
    logic [3:0]              new_idx_s;

    // Rotate requests so the search starts at rr_q, pick the lowest, then rotate the pick back.
    always_comb begin
        req_dbl_s  = {hbusreq, hbusreq} >> rr_q;
        pick_rot_s = lowest_set(req_dbl_s[MASTER_NUM-1:0]);
        pick_dbl_s = {pick_rot_s, pick_rot_s} << rr_q;
        pick_s     = pick_dbl_s[2*MASTER_NUM-1:MASTER_NUM];
        new_idx_s  = onehot_to_idx(hgrant_d);
        rr_d       = (new_idx_s == DEFAULT_IDX) ? 4'd0 : (new_idx_s + 4'd1);
    end

    // Rotation pointer follows each hand-over to a master that is actually requesting.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            rr_q <= 4'd0;
        end else if (hready && arb_ok_s && (hgrant_d != hgrant_q) && (|(hgrant_d & hbusreq))) begin
            rr_q <= rr_d;
        end else begin
            rr_q <= rr_q;
        end
    end
`else
    // Fixed priority pick.
    always_comb begin
        pick_s = lowest_set(hbusreq);
    end
`endif

    // Candidate grant: a locked grantee keeps the bus, an idle bus parks on the default master.
    always_comb begin
        hgrant_d = hgrant_q;
        if (lock_hold_s) begin
            hgrant_d = hgrant_q;
        end else if (hbusreq == {MASTER_NUM{1'b0}}) begin
            hgrant_d = DEFAULT_GNT;
        end else begin
            hgrant_d = pick_s;
        end
    end

    // Grant, owner and beat counter; hready low freezes grant and owner.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_q  <= DEFAULT_GNT;
            hmaster_q <= DEFAULT_IDX;
            cnt_q     <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            if (hready) begin
                hmaster_q <= onehot_to_idx(hgrant_q);
                hgrant_q  <= arb_ok_s ? hgrant_d : hgrant_q;
            end else begin
                hmaster_q <= hmaster_q;
                hgrant_q  <= hgrant_q;
            end
        end
    end

    assign hgrant  = hgrant_q;
    assign hmaster = hmaster_q;

endmodule
